// File: rtl/map_pkg.sv
// Shared definitions for the map tile consumer: tile codes, default map
// geometry, score values and the consumer FSM state encoding.
package map_pkg;

    localparam int MAP_WIDTH_DEF     = 21;
    localparam int MAP_HEIGHT_DEF    = 21;
    localparam int PELLET_POINTS_DEF = 10;
    localparam int POWER_POINTS_DEF  = 50;

    localparam logic [2:0] TILE_EMPTY  = 3'd0;
    localparam logic [2:0] TILE_WALL   = 3'd1;
    localparam logic [2:0] TILE_PELLET = 3'd2;
    localparam logic [2:0] TILE_POWER  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Only pellets and power pellets are eaten; codes 4-7 are left alone.
    function automatic logic is_consumable(input logic [2:0] code);
        return (code == TILE_PELLET) || (code == TILE_POWER);
    endfunction

endpackage

// File: rtl/score_keeper.sv
// Saturating score accumulator and remaining-pellet down-counter, updated
// by single-cycle strobes issued while the consumer is writing EMPTY back.
module score_keeper
    import map_pkg::*;
#(
    parameter int INITIAL_PELLETS = 200,
    parameter int PELLET_POINTS   = PELLET_POINTS_DEF,
    parameter int POWER_POINTS    = POWER_POINTS_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        add_pellet_i,
    input  logic        add_power_i,
    output logic [15:0] score_o,
    output logic [8:0]  pellets_left_o,
    output logic        all_eaten_o
);

    localparam logic [15:0] PELLET_INC   = 16'(PELLET_POINTS);
    localparam logic [15:0] POWER_INC    = 16'(POWER_POINTS);
    localparam logic [8:0]  PELLET_START = 9'(INITIAL_PELLETS);

    logic [15:0] score_q, score_d;
    logic [8:0]  pellets_q, pellets_d;

    // Adds without wrapping: an overflow pins the result at 16'hFFFF.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Decrements without wrapping: zero stays zero.
    function automatic logic [8:0] sat_dec9(input logic [8:0] a);
        return (a == 9'd0) ? 9'd0 : a - 9'd1;
    endfunction

    // Next score / pellet count from the eat strobes.
    always_comb begin
        score_d   = score_q;
        pellets_d = pellets_q;
        if (add_pellet_i) begin
            score_d   = sat_add16(score_q, PELLET_INC);
            pellets_d = sat_dec9(pellets_q);
        end else if (add_power_i) begin
            score_d   = sat_add16(score_q, POWER_INC);
            pellets_d = sat_dec9(pellets_q);
        end
    end

    // Counter registers, restored to the start-of-game values on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            score_q   <= 16'd0;
            pellets_q <= PELLET_START;
        end else begin
            score_q   <= score_d;
            pellets_q <= pellets_d;
        end
    end

    assign score_o        = score_q;
    assign pellets_left_o = pellets_q;
    assign all_eaten_o    = (pellets_q == 9'd0);

endmodule

// File: rtl/map_tile_consumer.sv
// Read-modify-write front end for the map RAM controller: reads the tile
// under Pac-Man, clears it if it holds a pellet or power pellet, updates the
// score/pellet counters and pulses done with the outcome flags.
module map_tile_consumer
    import map_pkg::*;
#(
    parameter int MAP_WIDTH       = MAP_WIDTH_DEF,
    parameter int MAP_HEIGHT      = MAP_HEIGHT_DEF,
    parameter int READ_LATENCY    = 1,
    parameter int INITIAL_PELLETS = 200,
    parameter int PELLET_POINTS   = PELLET_POINTS_DEF,
    parameter int POWER_POINTS    = POWER_POINTS_DEF
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        req,
    input  logic [4:0]  tile_x,
    input  logic [4:0]  tile_y,
    output logic        busy,
    output logic        done,
    output logic        ate_pellet,
    output logic        ate_power,
    output logic        bad_coord,
    output logic [15:0] score,
    output logic [8:0]  pellets_left,
    output logic        all_eaten,
    output logic [4:0]  map_x,
    output logic [4:0]  map_y,
    output logic [2:0]  sprite_data_out,
    output logic        readwrite,
    input  logic [2:0]  sprite_data_in
);

    // Last WAIT count before the read data is valid at the controller output.
    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_e      state_q, state_d;
    logic [4:0]  map_x_q, map_x_d;
    logic [4:0]  map_y_q, map_y_d;
    logic [2:0]  tile_q, tile_d;
    logic        bad_q, bad_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic        in_range;
    logic        add_pellet;
    logic        add_power;

    assign in_range = (int'(tile_x) < MAP_WIDTH) && (int'(tile_y) < MAP_HEIGHT);

    // State register; reset aborts any transaction at the next edge.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: out-of-range requests skip the RAM entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (req) state_d = in_range ? ST_ISSUE : ST_DONE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = ST_EVAL;
            ST_EVAL:  state_d = is_consumable(sprite_data_in) ? ST_WRITE : ST_DONE;
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Transaction context: address latched on accept, tile code captured in EVAL.
    always_comb begin
        map_x_d    = map_x_q;
        map_y_d    = map_y_q;
        tile_d     = tile_q;
        bad_d      = bad_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    map_x_d = tile_x;
                    map_y_d = tile_y;
                    tile_d  = TILE_EMPTY;
                    bad_d   = !in_range;
                end
            end
            ST_ISSUE: wait_cnt_d = 2'd0;
            ST_WAIT:  wait_cnt_d = wait_cnt_q + 2'd1;
            ST_EVAL:  tile_d = sprite_data_in;
            default: ;
        endcase
    end

    // Context registers; address and flags return to known values on reset.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            map_x_q    <= 5'd0;
            map_y_q    <= 5'd0;
            tile_q     <= TILE_EMPTY;
            bad_q      <= 1'b0;
            wait_cnt_q <= 2'd0;
        end else begin
            map_x_q    <= map_x_d;
            map_y_q    <= map_y_d;
            tile_q     <= tile_d;
            bad_q      <= bad_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs decoded from state; flags exist only while done is high.
    always_comb begin
        busy            = (state_q != ST_IDLE);
        done            = (state_q == ST_DONE);
        readwrite       = (state_q == ST_WRITE);
        ate_pellet      = (state_q == ST_DONE) && (tile_q == TILE_PELLET);
        ate_power       = (state_q == ST_DONE) && (tile_q == TILE_POWER);
        bad_coord       = (state_q == ST_DONE) && bad_q;
        add_pellet      = (state_q == ST_WRITE) && (tile_q == TILE_PELLET);
        add_power       = (state_q == ST_WRITE) && (tile_q == TILE_POWER);
        map_x           = map_x_q;
        map_y           = map_y_q;
        sprite_data_out = TILE_EMPTY;
    end

    score_keeper #(
        .INITIAL_PELLETS (INITIAL_PELLETS),
        .PELLET_POINTS   (PELLET_POINTS),
        .POWER_POINTS    (POWER_POINTS)
    ) u_score (
        .clk_i          (clock_50),
        .rst_i          (reset),
        .add_pellet_i   (add_pellet),
        .add_power_i    (add_power),
        .score_o        (score),
        .pellets_left_o (pellets_left),
        .all_eaten_o    (all_eaten)
    );

endmodule

// File: tb/tb_map_tile_consumer.sv
// Bench for map_tile_consumer: a behavioural map RAM plus a transaction-level
// reference model of score, pellet count, latency and the map contents.
module tb_map_tile_consumer;

    localparam int W    = 21;
    localparam int H    = 21;
    localparam int RL   = 1;
    localparam int INIT = 200;

    logic        clock_50 = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [4:0]  tile_x = 5'd0;
    logic [4:0]  tile_y = 5'd0;
    logic        busy, done, ate_pellet, ate_power, bad_coord, all_eaten, readwrite;
    logic [15:0] score;
    logic [8:0]  pellets_left;
    logic [4:0]  map_x, map_y;
    logic [2:0]  sprite_data_out;
    logic [2:0]  ram_q = 3'd0;

    // RAM model and monitor state
    logic [2:0]  mem [0:W*H-1];
    logic        pl_en = 1'b0;
    int          pl_addr = 0;
    logic [2:0]  pl_data = 3'd0;
    int          wr_count = 0;
    int          wr_addr = 0;
    logic [2:0]  wr_data = 3'd0;
    int          done_count = 0;
    int          ram_a;

    // Reference model state
    int          ref_map [0:W*H-1];
    int          exp_score = 0;
    int          exp_pel = INIT;
    int          checks = 0;
    int          errors = 0;

    always #5 clock_50 = ~clock_50;

    map_tile_consumer #(
        .MAP_WIDTH(W), .MAP_HEIGHT(H), .READ_LATENCY(RL), .INITIAL_PELLETS(INIT),
        .PELLET_POINTS(10), .POWER_POINTS(50)
    ) dut (
        .clock_50(clock_50), .reset(reset), .req(req), .tile_x(tile_x), .tile_y(tile_y),
        .busy(busy), .done(done), .ate_pellet(ate_pellet), .ate_power(ate_power),
        .bad_coord(bad_coord), .score(score), .pellets_left(pellets_left),
        .all_eaten(all_eaten), .map_x(map_x), .map_y(map_y),
        .sprite_data_out(sprite_data_out), .readwrite(readwrite),
        .sprite_data_in(ram_q)
    );

    assign ram_a = int'(map_y) * W + int'(map_x);

    // Map RAM with one clock of read latency, plus write/done monitors.
    always @(posedge clock_50) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (readwrite && ram_a < W*H) mem[ram_a] <= sprite_data_out;
        ram_q <= (ram_a < W*H) ? mem[ram_a] : 3'd0;
        if (readwrite) begin
            wr_count <= wr_count + 1;
            wr_addr  <= ram_a;
            wr_data  <= sprite_data_out;
        end
        if (done) done_count <= done_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int x, input int y, input int code);
        pl_en = 1'b1; pl_addr = y * W + x; pl_data = 3'(code);
        @(negedge clock_50);
        pl_en = 1'b0;
        ref_map[y * W + x] = code;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_score"}, 32'(score), 32'(exp_score));
        chk({tag, "_pellets"}, 32'(pellets_left), 32'(exp_pel));
        chk({tag, "_all_eaten"}, 32'(all_eaten), 32'(exp_pel == 0));
    endtask

    // One request, judged against the model's view of that tile.
    task automatic run_txn(input int x, input int y);
        int a, code, exp_lat, cyc, wr0;
        bit inr, eat, seen;
        inr  = (x < W) && (y < H);
        a    = y * W + x;
        code = inr ? ref_map[a] : 0;
        eat  = inr && (code == 2 || code == 3);
        exp_lat = !inr ? 1 : (eat ? 4 + RL : 3 + RL);
        if (eat) begin
            exp_score = exp_score + (code == 2 ? 10 : 50);
            if (exp_score > 65535) exp_score = 65535;
            if (exp_pel > 0) exp_pel--;
            ref_map[a] = 0;
        end
        wr0 = wr_count;
        req = 1'b1; tile_x = 5'(x); tile_y = 5'(y);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clock_50);
            cyc++;
            req = 1'b0;
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("ate_pellet", 32'(ate_pellet), 32'(inr && code == 2));
        chk("ate_power", 32'(ate_power), 32'(inr && code == 3));
        chk("bad_coord", 32'(bad_coord), 32'(!inr));
        chk("write_count", 32'(wr_count - wr0), 32'(eat));
        if (eat) begin
            chk("write_addr", 32'(wr_addr), 32'(a));
            chk("write_data", 32'(wr_data), 32'd0);
        end
        if (inr) chk("map_cell", 32'(mem[a]), 32'(ref_map[a]));
        check_counters("txn");
        @(negedge clock_50);
        chk("done_clear", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int c1, c2, cyc, d0, w0;
        for (int i = 0; i < W*H; i++) ref_map[i] = 0;

        // Reset values
        repeat (3) @(negedge clock_50);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rw", 32'(readwrite), 32'd0);
        chk("rst_flags", {29'd0, ate_pellet, ate_power, bad_coord}, 32'd0);
        chk("rst_map_xy", {22'd0, map_x, map_y}, 32'd0);
        chk("rst_wdata", 32'(sprite_data_out), 32'd0);
        check_counters("rst");
        reset = 1'b0;
        @(negedge clock_50);

        // Pellet at (3,4), address 87
        preload(3, 4, 2);
        run_txn(3, 4);
        chk("pellet_score", 32'(score), 32'd10);
        chk("pellet_left", 32'(pellets_left), 32'd199);

        // Power at (10,10), then the now-empty tile again
        preload(10, 10, 3);
        run_txn(10, 10);
        run_txn(10, 10);
        chk("power_score", 32'(score), 32'd60);

        // Wall and out-of-range column
        preload(0, 0, 1);
        run_txn(0, 0);
        run_txn(21, 5);
        run_txn(4, 27);

        // req held high across DONE restarts from the following IDLE cycle
        req = 1'b1; tile_x = 5'd0; tile_y = 5'd0;
        cyc = 0; c1 = 0; c2 = 0;
        while (c2 == 0 && cyc < 30) begin
            @(negedge clock_50);
            cyc++;
            if (done) begin
                if (c1 == 0) c1 = cyc; else c2 = cyc;
            end
        end
        req = 1'b0;
        chk("held_first", 32'(c1), 32'(3 + RL));
        chk("held_second", 32'(c2), 32'(2 * (3 + RL) + 1));
        repeat (2) @(negedge clock_50);

        // req while busy is ignored
        preload(5, 5, 1);
        preload(6, 6, 2);
        d0 = done_count; w0 = wr_count;
        req = 1'b1; tile_x = 5'd5; tile_y = 5'd5;
        @(negedge clock_50);
        req = 1'b0;
        @(negedge clock_50);
        req = 1'b1; tile_x = 5'd6; tile_y = 5'd6;
        @(negedge clock_50);
        req = 1'b0;
        repeat (12) @(negedge clock_50);
        chk("busy_req_dones", 32'(done_count - d0), 32'd1);
        chk("busy_req_writes", 32'(wr_count - w0), 32'd0);
        check_counters("busy_req");

        // Randomised tiles and coordinates
        for (int n = 0; n < 60; n++) begin
            int x, y;
            x = int'($urandom_range(23, 0));
            y = int'($urandom_range(23, 0));
            if (x < W && y < H) preload(x, y, int'($urandom_range(7, 0)));
            run_txn(x, y);
        end

        // Drive the score toward saturation; the pellet count bottoms out on the way
        while (exp_score + 50 <= 16'hFFF0) begin
            preload(1, 1, 3);
            run_txn(1, 1);
        end
        while (exp_score + 10 <= 16'hFFF0) begin
            preload(1, 2, 2);
            run_txn(1, 2);
        end
        chk("near_max", 32'(score), 32'hFFF0);
        chk("pellets_floor", 32'(pellets_left), 32'd0);
        chk("all_eaten", 32'(all_eaten), 32'd1);
        preload(2, 2, 3);
        run_txn(2, 2);
        chk("score_sat", 32'(score), 32'hFFFF);
        preload(2, 3, 2);
        run_txn(2, 3);
        chk("score_sat_hold", 32'(score), 32'hFFFF);

        // Reset during WAIT aborts with no write and restores counters
        preload(7, 7, 2);
        w0 = wr_count;
        req = 1'b1; tile_x = 5'd7; tile_y = 5'd7;
        @(negedge clock_50);
        req = 1'b0;
        @(negedge clock_50);
        chk("wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock_50);
        exp_score = 0; exp_pel = INIT;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rw", 32'(readwrite), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        check_counters("abort");
        reset = 1'b0;
        repeat (4) @(negedge clock_50);
        chk("abort_no_write", 32'(wr_count - w0), 32'd0);
        chk("abort_cell", 32'(mem[7 * W + 7]), 32'd2);
        run_txn(7, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
